order_manager: RTL and testbench
================================

# order_manager

Upstream order/score engine for the kitchen display. Keeps up to four concurrent customer orders, each with a per-second countdown. Spawns new orders on a fixed interval, matches dish deliveries against the oldest order, and keeps a saturating point total. Its registered outputs drive the order strip and score fields of the graphics stage directly: `orders`, `order_times` and `point_total`.

## Interface
Parameters:
- `CLK_HZ`, 65_000_000: clock cycles per game second.
- `ORDER_LIFE`, 30: seconds loaded into a new order's timer. Range 1..31.
- `SPAWN_INTERVAL`, 10: seconds between spawn attempts. Range 1..31.
- `BASE_POINTS`, 20: points per delivery before the time bonus.
- `EXPIRE_PENALTY`, 10: points removed per expired order.
- `MAX_POINTS`, 999: saturation ceiling for `point_total`.

Ports:
- `clock`, in, 1: pixel/system clock.
- `reset`, in, 1: asynchronous, active-high.
- `game_state`, in, 3: WELCOME=0, START=1, PLAY=2, PAUSE=3, FINISH=4.
- `deliver_valid`, in, 1: one-cycle pulse when a player drops a finished dish at the serving window.
- `deliver_ack`, out, 1: registered pulse; the delivery was matched to an order.
- `deliver_nack`, out, 1: registered pulse; the delivery was rejected.
- `orders`, out, 4: bit i set means slot i holds an active order.
- `order_times`, out, 4x5: seconds remaining per slot. A free slot reads 0.
- `point_total`, out, 10: score, 0..MAX_POINTS.
- `second_tick`, out, 1: one-cycle pulse per elapsed game second. Provided for the round timer.

## Operation
- Mode is taken from `game_state` each cycle. Values 5..7 are treated as WELCOME.
- WELCOME, START:
  - Clear all slots, `point_total` and the prescaler.
  - Load the spawn counter with 1, so the first order appears 1 s after PLAY begins.
  - Deliveries produce `deliver_nack`.
- PLAY: prescaler runs; ticks, spawns, expiries and deliveries are all live.
- PAUSE: prescaler, timers and spawn counter hold. Deliveries produce `deliver_nack`.
- FINISH: same as PAUSE. `point_total` holds for the results screen.
- Tick processing (PLAY only, on the cycle the prescaler reaches CLK_HZ-1):
  - Every active slot with time > 1 decrements by 1.
  - An active slot with time == 1 expires: the slot is cleared and EXPIRE_PENALTY is applied.
  - Penalties from all expiries in the same tick are summed.
  - Spawn counter decrements.
  - When the spawn counter reaches 0 and a free slot exists, the lowest-index free slot is loaded with ORDER_LIFE and the counter reloads with SPAWN_INTERVAL.
  - If no slot is free, the counter stays at 0 and a spawn is retried on every later tick.
  - Spawn eligibility uses slot occupancy from before the current cycle. A slot freed this cycle is not refilled in the same cycle.
- Delivery (PLAY only):
  - The target is the active slot with the smallest time remaining. Ties go to the lowest index.
  - That slot is cleared, and BASE_POINTS + (time >> 2) is added, using the time value before this cycle.
  - No active slot: `deliver_nack`, score unchanged.
- Delivery on a tick cycle:
  - Delivery selection uses the pre-tick state.
  - A slot that is both delivered and expiring counts as delivered. No penalty is applied.
  - The other slots tick normally.
- Score arithmetic:
  - Computed in 11 bits: additions minus penalties in the same cycle.
  - Clamped to 0..MAX_POINTS before registering.

## Timing
- Reset value of every output is 0. The spawn counter resets to 1 and the prescaler to 0.
- `second_tick` is high in the cycle after the prescaler reaches CLK_HZ-1. That cycle is the one in which the slot and score registers show the updated values.
- `deliver_ack`/`deliver_nack` fire exactly one cycle after `deliver_valid`, coincident with the updated slot and score.
- `deliver_valid` held high for N cycles is treated as N deliveries. The upstream player logic guarantees single-cycle pulses.
- Entering PLAY from PAUSE resumes the prescaler at its held count. No partial second is lost or gained.
- Asserting `reset` at any point, including mid-tick or mid-delivery, clears all state immediately with no glitch on outputs.

## Structure
- `game_pkg` holds:
  - the game_state localparams (WELCOME..FINISH);
  - NUM_ORDER_SLOTS=4;
  - the 5-bit order time width;
  - the 10-bit score width.
  The graphics and game-control blocks share these.
- Sub-module `second_ticker` contains the prescaler only: inputs `clock`, `reset`, `run`, `clear`; output `tick`. It is reused by the round timer.
- Slot state is an array of valid bits plus an array of 5-bit times. Min-time selection and free-slot selection are combinational priority logic over 4 entries.

## Test plan
All scenarios run with CLK_HZ=4, ORDER_LIFE=3, SPAWN_INTERVAL=2 unless stated.
- Reset, then START, then PLAY for 5 cycles.
  - Response: at the first tick, `orders`=0001 and slot 0 time=3. `point_total`=0.
- No deliveries, 4 ticks.
  - Response: slot 0 counts 3,2,1, then expires. Score stays 0 (clamped).
  - Repeat from 100 points: the score reads 90 after the expiry.
- Slot 0 at time 3, slot 1 at time 1, `deliver_valid` on a non-tick cycle.
  - Response: slot 1 cleared, `deliver_ack` the next cycle.
  - `point_total` rises by 20 + (1>>2) = 20.
- `deliver_valid` on the same cycle a tick expires the targeted slot.
  - Response: `deliver_ack`, +20 points, no penalty.
- All 4 slots full with the spawn counter at 0.
  - Response: no spawn.
  - After a delivery frees slot 2, the next tick loads slot 2 with 3.
- PAUSE for 20 cycles mid-second, then PLAY.
  - Response: `second_tick` resumes after the remaining prescaler count. Times are unchanged during PAUSE.
  - A delivery during PAUSE gives `deliver_nack`.
- Score at 995 and a delivery with time 31.
  - Response: `point_total`=999 (saturated).

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions for the order/score engine, graphics and game control.
// Contents:
//   game_state_e     - encoding of the game_state bus (WELCOME..FINISH)
//   NUM_ORDER_SLOTS  - concurrent customer orders
//   ORDER_TIME_W     - width of a per-order seconds counter
//   SCORE_W          - width of the displayed point total
//   play_mode_e      - collapsed run/hold/idle view of game_state
package game_pkg;

    typedef enum logic [2:0] {
        WELCOME = 3'd0,
        START   = 3'd1,
        PLAY    = 3'd2,
        PAUSE   = 3'd3,
        FINISH  = 3'd4
    } game_state_e;

    localparam int unsigned NUM_ORDER_SLOTS = 4;
    localparam int unsigned SLOT_IDX_W      = 2;
    localparam int unsigned ORDER_TIME_W    = 5;
    localparam int unsigned SCORE_W         = 10;
    // One extra bit so a delivery bonus on top of a near-full score cannot wrap.
    localparam int unsigned SCORE_CALC_W    = SCORE_W + 1;

    typedef enum logic [1:0] {
        MODE_IDLE,  // WELCOME, START and unused encodings: clear everything
        MODE_RUN,   // PLAY: game clock and deliveries live
        MODE_HOLD   // PAUSE, FINISH: freeze state
    } play_mode_e;

    function automatic play_mode_e decode_mode(input logic [2:0] gs);
        play_mode_e m;
        case (gs)
            PLAY:          m = MODE_RUN;
            PAUSE, FINISH: m = MODE_HOLD;
            default:       m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/second_ticker.sv
// Game-second prescaler.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   run          - count while high, hold count while low
//   clear        - synchronous return to count 0 (wins over run)
//   tick         - high during the cycle the count sits at CLK_HZ-1 while running;
//                  consumers register it together with their per-second update
module second_ticker #(
    parameter int unsigned CLK_HZ = 65_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned       CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        tick = run && !clear && (count == LAST);
    end

endmodule

// File: rtl/order_manager.sv
// Order/score engine for the kitchen display.
// Holds up to four customer orders with per-second countdowns, spawns orders on a
// fixed interval, matches deliveries to the order closest to expiring, and keeps a
// saturating point total.
// Ports:
//   clock, reset            - system clock, asynchronous active-high reset
//   game_state              - WELCOME/START/PLAY/PAUSE/FINISH (5..7 act as WELCOME)
//   deliver_valid           - one pulse per dish dropped at the serving window
//   deliver_ack/nack        - registered verdict, one cycle after deliver_valid
//   orders                  - per-slot active flags
//   order_times             - per-slot seconds remaining (0 for a free slot)
//   point_total             - score, 0..MAX_POINTS
//   second_tick             - pulse in the cycle the per-second update becomes visible
module order_manager
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 65_000_000,
    parameter int unsigned ORDER_LIFE     = 30,
    parameter int unsigned SPAWN_INTERVAL = 10,
    parameter int unsigned BASE_POINTS    = 20,
    parameter int unsigned EXPIRE_PENALTY = 10,
    parameter int unsigned MAX_POINTS     = 999
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [2:0]                                   game_state,
    input  logic                                         deliver_valid,
    output logic                                         deliver_ack,
    output logic                                         deliver_nack,
    output logic [NUM_ORDER_SLOTS-1:0]                   orders,
    output logic [NUM_ORDER_SLOTS-1:0][ORDER_TIME_W-1:0] order_times,
    output logic [SCORE_W-1:0]                           point_total,
    output logic                                         second_tick
);

    localparam logic [ORDER_TIME_W-1:0] LIFE_T     = ORDER_TIME_W'(ORDER_LIFE);
    localparam logic [ORDER_TIME_W-1:0] INTERVAL_T = ORDER_TIME_W'(SPAWN_INTERVAL);
    localparam logic [SCORE_CALC_W-1:0] BASE_C     = SCORE_CALC_W'(BASE_POINTS);
    localparam logic [SCORE_CALC_W-1:0] PEN_C      = SCORE_CALC_W'(EXPIRE_PENALTY);
    localparam logic [SCORE_CALC_W-1:0] MAX_C      = SCORE_CALC_W'(MAX_POINTS);

    play_mode_e mode;
    logic       run;
    logic       clear;
    logic       tick;

    logic [NUM_ORDER_SLOTS-1:0]                   slot_valid, slot_valid_next;
    logic [NUM_ORDER_SLOTS-1:0][ORDER_TIME_W-1:0] slot_time, slot_time_next;
    logic [ORDER_TIME_W-1:0]                      spawn_cnt, spawn_cnt_next, spawn_dec;
    logic [SCORE_W-1:0]                           points, points_next;
    logic                                         ack_q, nack_q, tick_q;
    logic                                         ack_next, nack_next;

    logic                    tgt_found;
    logic [SLOT_IDX_W-1:0]   tgt_idx;
    logic [ORDER_TIME_W-1:0] tgt_time;
    logic                    free_found;
    logic [SLOT_IDX_W-1:0]   free_idx;
    logic                    deliver_hit;

    logic [SCORE_CALC_W-1:0] add_pts, pen_pts, sum_pts, net_pts;

    always_comb begin
        mode  = decode_mode(game_state);
        run   = (mode == MODE_RUN);
        clear = (mode == MODE_IDLE);
    end

    second_ticker #(
        .CLK_HZ (CLK_HZ)
    ) u_second_ticker (
        .clock (clock),
        .reset (reset),
        .run   (run),
        .clear (clear),
        .tick  (tick)
    );

    // Delivery target: active slot with least time left; strict '<' keeps the
    // lowest index on ties.
    always_comb begin
        tgt_found = 1'b0;
        tgt_idx   = '0;
        tgt_time  = '1;
        for (int unsigned i = 0; i < NUM_ORDER_SLOTS; i++) begin
            if (slot_valid[i] && (!tgt_found || (slot_time[i] < tgt_time))) begin
                tgt_found = 1'b1;
                tgt_idx   = SLOT_IDX_W'(i);
                tgt_time  = slot_time[i];
            end
        end
    end

    // Spawn target: lowest-index slot that was free before this cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_ORDER_SLOTS; i++) begin
            if (!slot_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_IDX_W'(i);
            end
        end
    end

    always_comb begin
        deliver_hit = run && deliver_valid && tgt_found;
        ack_next    = deliver_valid && deliver_hit;
        nack_next   = deliver_valid && !deliver_hit;
        spawn_dec   = (spawn_cnt == '0) ? '0 : spawn_cnt - ORDER_TIME_W'(1);
    end

    // Slot and spawn-counter next state. A delivered slot is handled before the
    // expiry check so a slot that is delivered on its final tick earns no penalty.
    always_comb begin
        slot_valid_next = slot_valid;
        slot_time_next  = slot_time;
        spawn_cnt_next  = spawn_cnt;
        pen_pts         = '0;
        case (mode)
            MODE_IDLE: begin
                slot_valid_next = '0;
                slot_time_next  = '0;
                spawn_cnt_next  = ORDER_TIME_W'(1);
            end
            MODE_RUN: begin
                for (int unsigned i = 0; i < NUM_ORDER_SLOTS; i++) begin
                    if (deliver_hit && (tgt_idx == SLOT_IDX_W'(i))) begin
                        slot_valid_next[i] = 1'b0;
                        slot_time_next[i]  = '0;
                    end else if (tick && slot_valid[i]) begin
                        if (slot_time[i] <= ORDER_TIME_W'(1)) begin
                            slot_valid_next[i] = 1'b0;
                            slot_time_next[i]  = '0;
                            pen_pts            = pen_pts + PEN_C;
                        end else begin
                            slot_time_next[i] = slot_time[i] - ORDER_TIME_W'(1);
                        end
                    end
                end
                if (tick) begin
                    // free_idx was free before this cycle, so it cannot collide with
                    // the delivery or expiry updates above.
                    if ((spawn_dec == '0) && free_found) begin
                        slot_valid_next[free_idx] = 1'b1;
                        slot_time_next[free_idx]  = LIFE_T;
                        spawn_cnt_next            = INTERVAL_T;
                    end else begin
                        spawn_cnt_next = spawn_dec;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Score: add bonus, subtract summed penalties without going below zero, clamp.
    always_comb begin
        add_pts = deliver_hit ? (BASE_C + SCORE_CALC_W'(tgt_time >> 2)) : '0;
        sum_pts = SCORE_CALC_W'(points) + add_pts;
        net_pts = (sum_pts < pen_pts) ? '0 : (sum_pts - pen_pts);
        if (mode == MODE_IDLE) begin
            points_next = '0;
        end else if (net_pts > MAX_C) begin
            points_next = SCORE_W'(MAX_C);
        end else begin
            points_next = SCORE_W'(net_pts);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            slot_time  <= '0;
            spawn_cnt  <= ORDER_TIME_W'(1);
            points     <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            slot_valid <= slot_valid_next;
            slot_time  <= slot_time_next;
            spawn_cnt  <= spawn_cnt_next;
            points     <= points_next;
            ack_q      <= ack_next;
            nack_q     <= nack_next;
            tick_q     <= tick;
        end
    end

    always_comb begin
        orders       = slot_valid;
        order_times  = slot_time;
        point_total  = points;
        deliver_ack  = ack_q;
        deliver_nack = nack_q;
        second_tick  = tick_q;
    end

endmodule

// File: tb/tb_order_manager.sv
module tb_order_manager;
    import game_pkg::*;

    typedef struct packed {
        logic        ack;
        logic        nack;
        logic        tick;
        logic [3:0]  orders;
        logic [19:0] times;
        logic [9:0]  pts;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [2:0]      a_gs, b_gs;
    logic            a_dv, b_dv;
    logic            a_ack, a_nack, a_tick, b_ack, b_nack, b_tick;
    logic [3:0]      a_orders, b_orders;
    logic [3:0][4:0] a_times, b_times;
    logic [9:0]      a_pts, b_pts;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   a_ev        = 0;
    int   b_ev        = 0;

    // Small game: 4-cycle seconds, 3 s orders, 2 s spawn interval.
    order_manager #(
        .CLK_HZ(4), .ORDER_LIFE(3), .SPAWN_INTERVAL(2),
        .BASE_POINTS(20), .EXPIRE_PENALTY(10), .MAX_POINTS(999)
    ) dut_a (
        .clock(clock), .reset(reset), .game_state(a_gs), .deliver_valid(a_dv),
        .deliver_ack(a_ack), .deliver_nack(a_nack), .orders(a_orders),
        .order_times(a_times), .point_total(a_pts), .second_tick(a_tick)
    );

    // Long orders, spawn every second: fills all slots and reaches saturation.
    order_manager #(
        .CLK_HZ(2), .ORDER_LIFE(31), .SPAWN_INTERVAL(1),
        .BASE_POINTS(20), .EXPIRE_PENALTY(10), .MAX_POINTS(999)
    ) dut_b (
        .clock(clock), .reset(reset), .game_state(b_gs), .deliver_valid(b_dv),
        .deliver_ack(b_ack), .deliver_nack(b_nack), .orders(b_orders),
        .order_times(b_times), .point_total(b_pts), .second_tick(b_tick)
    );

    function automatic exp_t mk(input logic ack, input logic nack, input logic tick,
                                input logic [3:0] ord, input int t0, input int t1,
                                input int t2, input int t3, input int pts);
        exp_t e;
        e.ack    = ack;
        e.nack   = nack;
        e.tick   = tick;
        e.orders = ord;
        e.times  = {5'(t3), 5'(t2), 5'(t1), 5'(t0)};
        e.pts    = 10'(pts);
        return e;
    endfunction

    task automatic compare_ev(input string nm, input int idx, input exp_t act, input exp_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s event %0d: got ack=%0b nack=%0b tick=%0b orders=%b times=%h points=%0d, expected ack=%0b nack=%0b tick=%0b orders=%b times=%h points=%0d",
                     nm, idx, act.ack, act.nack, act.tick, act.orders, act.times, act.pts,
                     exp.ack, exp.nack, exp.tick, exp.orders, exp.times, exp.pts);
        end
    endtask

    task automatic unexpected_ev(input string nm, input int idx, input exp_t act);
        vectors++;
        miscompares++;
        $display("FAIL %s event %0d: got ack=%0b nack=%0b tick=%0b orders=%b times=%h points=%0d, expected no event",
                 nm, idx, act.ack, act.nack, act.tick, act.orders, act.times, act.pts);
    endtask

    task automatic check_val(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every visible event (ack, nack or tick) consumes one expectation.
    always @(negedge clock) begin
        if (!reset && (a_ack || a_nack || a_tick)) begin
            a_ev++;
            if (qa.size() == 0)
                unexpected_ev("dut_a", a_ev, {a_ack, a_nack, a_tick, a_orders, a_times, a_pts});
            else
                compare_ev("dut_a", a_ev, {a_ack, a_nack, a_tick, a_orders, a_times, a_pts}, qa.pop_front());
        end
        if (!reset && (b_ack || b_nack || b_tick)) begin
            b_ev++;
            if (qb.size() == 0)
                unexpected_ev("dut_b", b_ev, {b_ack, b_nack, b_tick, b_orders, b_times, b_pts});
            else
                compare_ev("dut_b", b_ev, {b_ack, b_nack, b_tick, b_orders, b_times, b_pts}, qb.pop_front());
        end
    end

    task automatic step_a(input logic [2:0] gs, input logic dv);
        a_gs = gs;
        a_dv = dv;
        @(posedge clock);
        #1;
        a_dv = 1'b0;
    endtask

    task automatic run_a(input logic [2:0] gs, input int n);
        repeat (n) step_a(gs, 1'b0);
    endtask

    task automatic ev_a(input logic [2:0] gs, input logic dv, input exp_t e);
        qa.push_back(e);
        step_a(gs, dv);
    endtask

    task automatic step_b(input logic [2:0] gs, input logic dv);
        b_gs = gs;
        b_dv = dv;
        @(posedge clock);
        #1;
        b_dv = 1'b0;
    endtask

    task automatic run_b(input logic [2:0] gs, input int n);
        repeat (n) step_b(gs, 1'b0);
    endtask

    task automatic ev_b(input logic [2:0] gs, input logic dv, input exp_t e);
        qb.push_back(e);
        step_b(gs, dv);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_pts;
        reset = 1'b1;
        a_gs  = WELCOME;
        a_dv  = 1'b0;
        b_gs  = WELCOME;
        b_dv  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_val("a_reset_orders", int'(a_orders), 0);
        check_val("a_reset_times", int'(a_times), 0);
        check_val("a_reset_points", int'(a_pts), 0);
        check_val("a_reset_pulses", int'({a_ack, a_nack, a_tick}), 0);
        check_val("b_reset_orders", int'(b_orders), 0);
        reset = 1'b0;

        // ---------------- dut_a ----------------
        run_a(START, 2);
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0001, 3,0,0,0, 0));     // first order 1 s in
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0001, 2,0,0,0, 0));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0011, 1,3,0,0, 0));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0010, 0,2,0,0, 0));     // expiry, score clamps at 0
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0011, 3,1,0,0, 0));
        ev_a(PLAY, 1, mk(1,0,0, 4'b0001, 3,0,0,0, 20));    // min time is slot 1
        run_a(PLAY, 2);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0001, 2,0,0,0, 20));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0011, 1,3,0,0, 20));
        run_a(PLAY, 3);
        ev_a(PLAY, 1, mk(1,0,1, 4'b0010, 0,2,0,0, 40));    // delivered on its expiring tick
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0011, 3,1,0,0, 40));
        ev_a(PLAY, 1, mk(1,0,0, 4'b0001, 3,0,0,0, 60));
        ev_a(PLAY, 1, mk(1,0,0, 4'b0000, 0,0,0,0, 80));
        ev_a(PLAY, 1, mk(0,1,0, 4'b0000, 0,0,0,0, 80));    // nothing to deliver to
        ev_a(PLAY, 0, mk(0,0,1, 4'b0000, 0,0,0,0, 80));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0001, 3,0,0,0, 80));
        ev_a(PLAY, 1, mk(1,0,0, 4'b0000, 0,0,0,0, 100));
        run_a(PLAY, 2);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0000, 0,0,0,0, 100));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0001, 3,0,0,0, 100));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0001, 2,0,0,0, 100));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0011, 1,3,0,0, 100));
        run_a(PLAY, 3);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0010, 0,2,0,0, 90));    // penalty from 100
        run_a(PLAY, 2);                                     // prescaler now mid-second
        run_a(PAUSE, 4);
        ev_a(PAUSE, 1, mk(0,1,0, 4'b0010, 0,2,0,0, 90));   // delivery refused in PAUSE
        run_a(PAUSE, 15);
        check_val("a_pause_time_held", int'(a_times[1]), 2);
        check_val("a_pause_orders_held", int'(a_orders), 2);
        step_a(PLAY, 0);
        check_val("a_no_early_tick", int'(a_tick), 0);
        ev_a(PLAY, 0, mk(0,0,1, 4'b0011, 3,1,0,0, 90));
        check_val("a_tick_after_resume", int'(a_tick), 1);
        ev_a(FINISH, 1, mk(0,1,0, 4'b0011, 3,1,0,0, 90));
        run_a(FINISH, 5);
        check_val("a_finish_points_held", int'(a_pts), 90);
        step_a(3'd6, 0);                                    // unused encoding acts as WELCOME
        check_val("a_idle_orders_cleared", int'(a_orders), 0);
        check_val("a_idle_points_cleared", int'(a_pts), 0);
        check_val("a_idle_times_cleared", int'(a_times), 0);

        // ---------------- dut_b ----------------
        run_b(START, 2);
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b0001, 31,0,0,0, 0));
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b0011, 30,31,0,0, 0));
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b0111, 29,30,31,0, 0));
        ev_b(PLAY, 1, mk(1,0,0, 4'b0110, 0,30,31,0, 27));
        ev_b(PLAY, 0, mk(0,0,1, 4'b0111, 31,29,30,0, 27));
        ev_b(PLAY, 1, mk(1,0,0, 4'b0101, 31,0,30,0, 54));
        ev_b(PLAY, 0, mk(0,0,1, 4'b0111, 30,31,29,0, 54));
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b1111, 29,30,28,31, 54));
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b1111, 28,29,27,30, 54)); // full: spawn blocked
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b1111, 27,28,26,29, 54));
        ev_b(PLAY, 1, mk(1,0,0, 4'b1011, 27,28,0,29, 80));  // frees slot 2
        ev_b(PLAY, 0, mk(0,0,1, 4'b1111, 26,27,31,28, 80)); // retried spawn lands in slot 2
        run_b(PLAY, 1);
        ev_b(PLAY, 1, mk(1,0,1, 4'b1110, 0,26,30,27, 106)); // slot freed this cycle not refilled
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b1111, 31,25,29,26, 106));
        step_b(WELCOME, 0);
        step_b(START, 0);
        run_b(PLAY, 1);
        ev_b(PLAY, 0, mk(0,0,1, 4'b0001, 31,0,0,0, 0));
        for (int n = 1; n <= 38; n++) begin
            exp_pts = (27 * n > 999) ? 999 : 27 * n;
            ev_b(PLAY, 1, mk(1,0,0, 4'b0000, 0,0,0,0, exp_pts));
            ev_b(PLAY, 0, mk(0,0,1, 4'b0001, 31,0,0,0, exp_pts));
        end
        step_b(WELCOME, 0);

        repeat (4) @(posedge clock);
        #1;
        check_val("a_queue_drained", qa.size(), 0);
        check_val("b_queue_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
